// File: rtl/simple_ppu_cmd_queue_if.sv
// rtl/simple_ppu_cmd_queue_if.sv - CPU register port and PPU command port bundle
interface simple_ppu_cmd_queue_if;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [3:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        ppu_start;
    logic [7:0]  ppu_opcode;
    logic [31:0] ppu_arg0;
    logic [31:0] ppu_arg1;
    logic [31:0] ppu_arg2;
    logic [31:0] ppu_arg3;
    logic [31:0] ppu_arg4;
    logic [31:0] ppu_arg5;
    logic [31:0] ppu_arg6;
    logic        ppu_busy;
    logic        ppu_done;
    logic        queue_idle;

    modport slave (
        input  cpu_wr, cpu_rd, cpu_addr, cpu_wdata, ppu_busy, ppu_done,
        output cpu_rdata, ppu_start, ppu_opcode, queue_idle,
        output ppu_arg0, ppu_arg1, ppu_arg2, ppu_arg3, ppu_arg4, ppu_arg5, ppu_arg6
    );

    modport master (
        output cpu_wr, cpu_rd, cpu_addr, cpu_wdata, ppu_busy, ppu_done,
        input  cpu_rdata, ppu_start, ppu_opcode, queue_idle,
        input  ppu_arg0, ppu_arg1, ppu_arg2, ppu_arg3, ppu_arg4, ppu_arg5, ppu_arg6
    );
endinterface

// File: rtl/simple_ppu_cmd_queue.sv
// rtl/simple_ppu_cmd_queue.sv - register-window command FIFO and dispatcher for the PPU
module simple_ppu_cmd_queue #(
    parameter int DEPTH      = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    simple_ppu_cmd_queue_if.slave bus
);
    localparam int CW = DEPTH_LOG2 + 1;
    localparam int EW = 8 + 7 * 32;

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    logic [6:0][31:0]      arg_q;
    logic [EW-1:0]         mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [31:0]           rdata_q, rdata_d;
    state_t                state_q;
    logic                  ppu_start_q;
    logic [7:0]            ppu_opcode_q;
    logic [6:0][31:0]      ppu_arg_q;

    logic          push_req, push_ok, pop, flush, ovf_clr, full, empty;
    logic [31:0]   status;
    logic [EW-1:0] head;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign push_req = bus.cpu_wr && (bus.cpu_addr == 4'd7);
    assign flush    = bus.cpu_wr && (bus.cpu_addr == 4'd9) && bus.cpu_wdata[0];
    assign ovf_clr  = bus.cpu_wr && (bus.cpu_addr == 4'd8) && bus.cpu_wdata[19];
    // A full queue drops the push even when a pop frees a slot on the same edge.
    assign push_ok  = push_req && (!full || flush);
    assign pop      = (state_q == S_IDLE) && !empty && !bus.ppu_busy;
    assign head     = mem_q[rd_ptr_q];
    assign status   = {12'd0, overflow_q, state_q == S_WAIT, empty, full, 16'(count_q)};

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = push_ok ? CW'(1) : '0;
        end else begin
            rd_ptr_d = pop ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
            count_d  = count_q;
            if (push_ok && !pop) begin
                count_d = count_q + CW'(1);
            end else if (!push_ok && pop) begin
                count_d = count_q - CW'(1);
            end
        end
        overflow_d = overflow_q;
        if (ovf_clr) begin
            overflow_d = 1'b0;
        end
        if (push_req && !push_ok) begin
            overflow_d = 1'b1;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (bus.cpu_rd) begin
            case (bus.cpu_addr)
                4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: rdata_d = arg_q[bus.cpu_addr[2:0]];
                4'd8:    rdata_d = status;
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {bus.cpu_wdata[7:0], arg_q};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arg_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            if (bus.cpu_wr && (bus.cpu_addr < 4'd7)) begin
                arg_q[bus.cpu_addr[2:0]] <= bus.cpu_wdata;
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rdata_q    <= rdata_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            ppu_start_q  <= 1'b0;
            ppu_opcode_q <= '0;
            ppu_arg_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        ppu_opcode_q <= head[EW-1 -: 8];
                        ppu_arg_q    <= head[7*32-1:0];
                        ppu_start_q  <= 1'b1;
                        state_q      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    ppu_start_q <= 1'b0;
                    if (bus.ppu_done) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.cpu_rdata  = rdata_q;
    assign bus.ppu_start  = ppu_start_q;
    assign bus.ppu_opcode = ppu_opcode_q;
    assign bus.ppu_arg0   = ppu_arg_q[0];
    assign bus.ppu_arg1   = ppu_arg_q[1];
    assign bus.ppu_arg2   = ppu_arg_q[2];
    assign bus.ppu_arg3   = ppu_arg_q[3];
    assign bus.ppu_arg4   = ppu_arg_q[4];
    assign bus.ppu_arg5   = ppu_arg_q[5];
    assign bus.ppu_arg6   = ppu_arg_q[6];
    assign bus.queue_idle = empty && (state_q == S_IDLE);
endmodule

// File: doc/simple_ppu_cmd_queue.md
# simple_ppu_cmd_queue

Command front end for the simple PPU drawing engine. Presents a CPU-visible register window where software stages up to seven 32-bit arguments and an opcode. Each command write pushes a complete command into an internal FIFO. A dispatcher pops one command at a time and drives the PPU's `start`/`opcode`/`arg0..arg6` inputs, waiting for the PPU's `done` pulse before issuing the next command.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; must be a power of two, ≥2.
- `DEPTH_LOG2`, 3: log2(`DEPTH`).

Ports:
- `clk`  in  1  sole clock.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `cpu_wr`  in  1  single-cycle register write strobe.
- `cpu_rd`  in  1  single-cycle register read strobe.
- `cpu_addr`  in  4  register word index.
- `cpu_wdata`  in  32  write data.
- `cpu_rdata`  out  32  read data, registered; valid the cycle after `cpu_rd`.
- `ppu_start`  out  1  one-cycle command strobe to the PPU.
- `ppu_opcode`  out  8  opcode of the dispatched command.
- `ppu_arg0`..`ppu_arg6`  out  32 each  arguments of the dispatched command.
- `ppu_busy`  in  1  PPU busy flag.
- `ppu_done`  in  1  PPU one-cycle completion pulse.
- `queue_idle`  out  1  high when the FIFO is empty and no command is in flight.

## Operation
Register map (`cpu_addr`):
- 0–6 ARG0–ARG6: read/write staging registers.
- 7 CMD: a write pushes {`cpu_wdata[7:0]`, ARG0..ARG6 as they stand before this edge} into the FIFO. Reads return 0. Staging registers keep their values, so repeated commands need only a new CMD write.
- 8 STATUS: read layout:
  - [15:0] entry count.
  - [16] full.
  - [17] empty.
  - [18] in-flight.
  - [19] overflow (sticky).
  - Other bits 0.
  - Writing 1 to bit 19 clears overflow.
- 9 CONTROL: writing 1 to bit 0 flushes all queued entries. An in-flight command is unaffected. Reads return 0.
- 10–15: writes are ignored; reads return 0.

FIFO:
- Circular buffer with rd/wr pointers of `DEPTH_LOG2` bits that wrap modulo `DEPTH`.
- Count is `DEPTH_LOG2+1` bits.
- A push while full (pre-edge count == `DEPTH`) is dropped and sets overflow. This holds even if a pop occurs on the same edge.

Dispatcher FSM:
- S_IDLE: if the FIFO is non-empty (pre-edge) and `ppu_busy`=0:
  - load `ppu_opcode`/`ppu_arg*` from the FIFO head;
  - pop;
  - `ppu_start`<=1;
  - go to S_WAIT.
- S_WAIT: `ppu_start`<=0. On `ppu_done`=1, go to S_IDLE. In-flight = (state==S_WAIT).
- `ppu_opcode`/`ppu_arg*` hold their values until the next dispatch.
- `queue_idle` = empty && state==S_IDLE (combinational from registers).

Simultaneous events:
- Push and pop on the same edge: count unchanged, and both pointers advance.
- A push onto an empty FIFO is not dispatchable until the following edge.
- Flush and push on the same edge: flush applies first, the pushed entry survives, and count=1.
- Overflow set and clear on the same edge: set wins.
- CPU write and read to the same register on the same edge: `cpu_rdata` returns the pre-edge value.

Reset (assertion at any time, including mid-command):
- Every output goes to 0, except `queue_idle`, which goes to 1.
- ARG0–6 = 0, pointers = 0, overflow = 0, state S_IDLE, `cpu_rdata` = 0.
- The in-flight command is abandoned; the PPU shares `reset_n`.

## Timing
- CMD write at edge E into an empty FIFO with S_IDLE and `ppu_busy`=0:
  - pop and `ppu_start`=1 at edge E+1;
  - `ppu_start` is high for exactly the cycle E+1..E+2.
- `ppu_start` is never high for two consecutive cycles.
- `ppu_done` sampled at edge D returns the FSM to S_IDLE. The next `ppu_start` is asserted at edge D+1 if the FIFO is non-empty, giving a 1-cycle gap.
- `ppu_done` arriving in S_IDLE is ignored.
- A `ppu_start` is never issued while `ppu_busy`=1.
- `cpu_rdata`: one-cycle read latency; holds its value until the next `cpu_rd`.

## Test plan
- Reset → `ppu_start`=0, `queue_idle`=1; STATUS read = 0x0002_0000 (empty bit only).
- Write ARG0=5, ARG1=7, ARG2=0xF800; CMD=0x02 → one `ppu_start` pulse 2 cycles later with opcode 0x02 and args 5/7/0xF800. Assert `ppu_done` 10 cycles later → `queue_idle`=1.
- With `ppu_done` withheld, push 9 commands (`DEPTH`=8) → first dispatched, 8 queued. STATUS count=8, full=1, in-flight=1. Tenth push → overflow=1 and count stays 8. Write STATUS bit19 → overflow=0.
- Queue 3 commands with opcodes 0x01/0x03/0x04 and answer each `ppu_done` immediately → dispatched in order, with exactly 1 idle cycle between `done` and the next `start`.
- Queue 4 commands and issue CONTROL flush while the first is in flight → count=0. After `ppu_done`, no further `ppu_start`.
- Assert `reset_n`=0 mid-S_WAIT with 3 entries queued → outputs cleared immediately, FIFO empty, and no `ppu_start` after release.
